// File: rtl/dt_tick_sequencer_if.sv
`default_nettype none
// dt_tick_sequencer_if: control, theta request, result and dt-tick stream bundle.
// master = sequencer side, slave = compute chain / timing core side.
interface dt_tick_sequencer_if #(
  parameter int THETA_W_P    = 12,
  parameter int TICK_W_P     = 16,
  parameter int FIFO_DEPTH_P = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH_P) + 1;

  logic                 enable_i;
  logic                 bidir_i;
  logic                 theta_req_valid_o;
  logic                 theta_req_ready_i;
  logic [THETA_W_P-1:0] theta_req_o;
  logic                 res_valid_i;
  logic [TICK_W_P-1:0]  res_tick_i;
  logic                 tick_valid_o;
  logic                 tick_ready_i;
  logic [TICK_W_P-1:0]  tick_o;
  logic                 tick_dir_o;
  logic                 line_end_o;
  logic [LVL_W-1:0]     fifo_level_o;
  logic                 err_o;

  modport master (
    input  enable_i, bidir_i, theta_req_ready_i, res_valid_i, res_tick_i, tick_ready_i,
    output theta_req_valid_o, theta_req_o, tick_valid_o, tick_o, tick_dir_o,
           line_end_o, fifo_level_o, err_o
  );

  modport slave (
    output enable_i, bidir_i, theta_req_ready_i, res_valid_i, res_tick_i, tick_ready_i,
    input  theta_req_valid_o, theta_req_o, tick_valid_o, tick_o, tick_dir_o,
           line_end_o, fifo_level_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/dt_tick_sequencer.sv
`default_nettype none
// dt_tick_sequencer: mirror/wrap theta sweep generator with credit-protected,
// direction/line-end tagged dt-tick output FIFO.
module dt_tick_sequencer #(
  parameter int FRAME_COLUMNS_P = 360,
  parameter int THETA_W_P       = 12,
  parameter int TICK_W_P        = 16,
  parameter int FIFO_DEPTH_P    = 8
) (
  input logic clk_i,
  input logic rst_i,
  dt_tick_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH_P);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [THETA_W_P-1:0] THETA_LAST = THETA_W_P'(FRAME_COLUMNS_P - 1);
  localparam logic [LVL_W:0]       DEPTH_EXT  = (LVL_W + 1)'(FIFO_DEPTH_P);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FWD   = 2'd1,
    S_REV   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [THETA_W_P-1:0] theta, theta_nxt;
  logic                 bidir_mode, bidir_nxt;
  logic                 req_valid, req_valid_nxt;

  logic [LVL_W-1:0]     outstanding;
  logic                 tag_dir [FIFO_DEPTH_P];
  logic                 tag_le  [FIFO_DEPTH_P];
  logic [PTR_W-1:0]     tag_wr, tag_rd;

  logic [TICK_W_P-1:0]  mem_tick [FIFO_DEPTH_P];
  logic                 mem_dir  [FIFO_DEPTH_P];
  logic                 mem_le   [FIFO_DEPTH_P];
  logic [PTR_W-1:0]     fifo_wr, fifo_rd;
  logic [LVL_W-1:0]     level;
  logic                 err;

  logic accept, res_take, credit_ok, req_dir, req_line_end, fifo_pop;

  assign accept       = req_valid & bus.theta_req_ready_i;
  assign res_take     = bus.res_valid_i & (outstanding != '0);
  // Pending (not yet accepted) request is not charged; only one can exist at a time.
  assign credit_ok    = ({1'b0, level} + {1'b0, outstanding}) < DEPTH_EXT;
  assign req_dir      = (state == S_REV);
  assign req_line_end = req_dir ? (theta == '0) : (theta == THETA_LAST);
  assign fifo_pop     = (level != '0) & bus.tick_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      theta      <= '0;
      bidir_mode <= 1'b0;
      req_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      theta      <= theta_nxt;
      bidir_mode <= bidir_nxt;
      req_valid  <= req_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    theta_nxt     = theta;
    bidir_nxt     = bidir_mode;
    req_valid_nxt = req_valid;
    case (state)
      S_IDLE: begin
        if (bus.enable_i) begin
          state_nxt = S_FWD;
          theta_nxt = '0;
          bidir_nxt = bus.bidir_i;
        end
      end
      S_FWD, S_REV: begin
        if (req_valid) begin
          if (accept) begin
            req_valid_nxt = 1'b0;
            if (state == S_FWD) begin
              if (theta == THETA_LAST) begin
                if (bidir_mode) state_nxt = S_REV;
                else            theta_nxt = '0;
              end else begin
                theta_nxt = theta + THETA_W_P'(1);
              end
            end else begin
              if (theta == '0) state_nxt = S_FWD;
              else             theta_nxt = theta - THETA_W_P'(1);
            end
            if (!bus.enable_i) state_nxt = S_DRAIN;
          end
        end else if (!bus.enable_i) begin
          state_nxt = S_DRAIN;
        end else if (credit_ok) begin
          req_valid_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (outstanding == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tag queue mirrors the in-flight requests; results return in request order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      err         <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH_P; i++) begin
        tag_dir[i] <= 1'b0;
        tag_le[i]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        tag_dir[tag_wr] <= req_dir;
        tag_le[tag_wr]  <= req_line_end;
        tag_wr          <= tag_wr + PTR_W'(1);
      end
      if (res_take) tag_rd <= tag_rd + PTR_W'(1);
      if (accept && !res_take)      outstanding <= outstanding + LVL_W'(1);
      else if (!accept && res_take) outstanding <= outstanding - LVL_W'(1);
      if (bus.res_valid_i && outstanding == '0) err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_wr <= '0;
      fifo_rd <= '0;
      level   <= '0;
      for (int i = 0; i < FIFO_DEPTH_P; i++) begin
        mem_tick[i] <= '0;
        mem_dir[i]  <= 1'b0;
        mem_le[i]   <= 1'b0;
      end
    end else begin
      if (res_take) begin
        mem_tick[fifo_wr] <= bus.res_tick_i;
        mem_dir[fifo_wr]  <= tag_dir[tag_rd];
        mem_le[fifo_wr]   <= tag_le[tag_rd];
        fifo_wr           <= fifo_wr + PTR_W'(1);
      end
      if (fifo_pop) fifo_rd <= fifo_rd + PTR_W'(1);
      if (res_take && !fifo_pop)      level <= level + LVL_W'(1);
      else if (!res_take && fifo_pop) level <= level - LVL_W'(1);
    end
  end

  assign bus.theta_req_valid_o = req_valid;
  assign bus.theta_req_o       = theta;
  assign bus.tick_valid_o      = (level != '0);
  assign bus.tick_o            = mem_tick[fifo_rd];
  assign bus.tick_dir_o        = mem_dir[fifo_rd];
  assign bus.line_end_o        = mem_le[fifo_rd];
  assign bus.fifo_level_o      = level;
  assign bus.err_o             = err;
endmodule
`default_nettype wire

// File: tb/tb_dt_tick_sequencer.sv
`default_nettype none
// tb_dt_tick_sequencer: directed bench, 4 columns, depth-8 FIFO, compute-chain
// model with fixed latency 5 returning theta+100.
module tb_dt_tick_sequencer;
  localparam int FC = 4;
  localparam int TW = 12;
  localparam int KW = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dt_tick_sequencer_if #(.THETA_W_P(TW), .TICK_W_P(KW), .FIFO_DEPTH_P(DEPTH)) bus ();

  dt_tick_sequencer #(
    .FRAME_COLUMNS_P(FC), .THETA_W_P(TW), .TICK_W_P(KW), .FIFO_DEPTH_P(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct { int due; logic [TW-1:0] theta; } pend_t;
  typedef struct { logic [KW-1:0] tick; logic dir; logic le; } tick_t;

  pend_t         rq[$];
  logic [TW-1:0] req_log[$];
  tick_t         tick_log[$];
  int            cyc;
  bit            inject;
  int            n_tests = 0;
  int            n_fail  = 0;

  // Compute-chain model and stream monitor.
  initial begin
    cyc = 0;
    inject = 1'b0;
    bus.res_valid_i = 1'b0;
    bus.res_tick_i  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        bus.res_valid_i = 1'b1;
        bus.res_tick_i  = KW'(rq[0].theta) + KW'(100);
        void'(rq.pop_front());
      end else if (inject) begin
        bus.res_valid_i = 1'b1;
        bus.res_tick_i  = 16'hBEEF;
        inject = 1'b0;
      end else begin
        bus.res_valid_i = 1'b0;
      end
      @(negedge clk);
      if (bus.theta_req_valid_o && bus.theta_req_ready_i) begin
        rq.push_back('{cyc + 5, bus.theta_req_o});
        req_log.push_back(bus.theta_req_o);
      end
      if (bus.tick_valid_o && bus.tick_ready_i)
        tick_log.push_back('{bus.tick_o, bus.tick_dir_o, bus.line_end_o});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    bus.enable_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    req_log.delete();
    tick_log.delete();
  endtask

  task automatic quiesce();
    int k;
    step();
    bus.enable_i = 1'b0;
    bus.tick_ready_i = 1'b1;
    bus.theta_req_ready_i = 1'b1;
    k = 0;
    while ((rq.size() != 0 || bus.fifo_level_o != '0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    do_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (bus.theta_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", bus.theta_req_valid_o); end
    n_tests++; if (bus.theta_req_o !== '0) begin n_fail++; $display("FAIL rst_theta: got %0d expected 0", bus.theta_req_o); end
    n_tests++; if (bus.tick_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_tick_valid: got %b expected 0", bus.tick_valid_o); end
    n_tests++; if (bus.tick_o !== '0) begin n_fail++; $display("FAIL rst_tick: got %0d expected 0", bus.tick_o); end
    n_tests++; if (bus.tick_dir_o !== 1'b0) begin n_fail++; $display("FAIL rst_dir: got %b expected 0", bus.tick_dir_o); end
    n_tests++; if (bus.line_end_o !== 1'b0) begin n_fail++; $display("FAIL rst_line_end: got %b expected 0", bus.line_end_o); end
    n_tests++; if (bus.fifo_level_o !== '0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", bus.fifo_level_o); end
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", bus.err_o); end
  endtask

  task automatic test_sweep(input bit bidir, input int n);
    int exp_bi[12] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3};
    int exp_wr[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int k, th;
    bit dir, le;
    step();
    bus.bidir_i = bidir;
    bus.theta_req_ready_i = 1'b1;
    bus.tick_ready_i = 1'b1;
    bus.enable_i = 1'b1;
    k = 0;
    while (tick_log.size() < n && k < 300) begin @(negedge clk); k++; end
    n_tests++;
    if (tick_log.size() < n) begin n_fail++; $display("FAIL sweep%0d_timeout: got %0d ticks expected %0d", bidir, tick_log.size(), n); end
    for (int i = 0; i < n; i++) begin
      th  = bidir ? exp_bi[i] : exp_wr[i];
      dir = bidir && (i % 8) >= 4;
      le  = (i % 4) == 3;
      if (i < req_log.size()) begin
        n_tests++; if (int'(req_log[i]) != th) begin n_fail++; $display("FAIL sweep%0d_theta[%0d]: got %0d expected %0d", bidir, i, req_log[i], th); end
      end
      if (i < tick_log.size()) begin
        n_tests++; if (int'(tick_log[i].tick) != th + 100) begin n_fail++; $display("FAIL sweep%0d_tick[%0d]: got %0d expected %0d", bidir, i, tick_log[i].tick, th + 100); end
        n_tests++; if (tick_log[i].dir !== dir) begin n_fail++; $display("FAIL sweep%0d_dir[%0d]: got %b expected %b", bidir, i, tick_log[i].dir, dir); end
        n_tests++; if (tick_log[i].le !== le) begin n_fail++; $display("FAIL sweep%0d_line_end[%0d]: got %b expected %b", bidir, i, tick_log[i].le, le); end
      end
    end
    quiesce();
  endtask

  task automatic test_credit();
    step();
    bus.bidir_i = 1'b1;
    bus.theta_req_ready_i = 1'b1;
    bus.tick_ready_i = 1'b0;
    bus.enable_i = 1'b1;
    repeat (60) @(negedge clk);
    n_tests++; if (req_log.size() != DEPTH) begin n_fail++; $display("FAIL credit_reqs: got %0d expected %0d", req_log.size(), DEPTH); end
    n_tests++; if (bus.theta_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL credit_valid: got %b expected 0", bus.theta_req_valid_o); end
    n_tests++; if (bus.fifo_level_o !== 4'd8) begin n_fail++; $display("FAIL credit_level: got %0d expected 8", bus.fifo_level_o); end
    step();
    bus.tick_ready_i = 1'b1;
    step();
    bus.tick_ready_i = 1'b0;
    repeat (30) @(negedge clk);
    n_tests++; if (req_log.size() != DEPTH + 1) begin n_fail++; $display("FAIL credit_reqs_after_pop: got %0d expected %0d", req_log.size(), DEPTH + 1); end
    if (req_log.size() > DEPTH) begin
      n_tests++; if (req_log[DEPTH] !== 12'd0) begin n_fail++; $display("FAIL credit_ninth_theta: got %0d expected 0", req_log[DEPTH]); end
    end
    n_tests++; if (bus.fifo_level_o !== 4'd8) begin n_fail++; $display("FAIL credit_level_refill: got %0d expected 8", bus.fifo_level_o); end
    n_tests++; if (tick_log.size() != 1) begin n_fail++; $display("FAIL credit_pops: got %0d expected 1", tick_log.size()); end
    if (tick_log.size() > 0) begin
      n_tests++; if (tick_log[0].tick !== 16'd100) begin n_fail++; $display("FAIL credit_first_tick: got %0d expected 100", tick_log[0].tick); end
    end
    quiesce();
  endtask

  task automatic test_stall_drain();
    int k;
    step();
    bus.bidir_i = 1'b1;
    bus.theta_req_ready_i = 1'b0;
    bus.tick_ready_i = 1'b1;
    bus.enable_i = 1'b1;
    k = 0;
    while (bus.theta_req_valid_o !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_tests++; if (bus.theta_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: got valid %b expected 1", bus.theta_req_valid_o); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++; if (bus.theta_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.theta_req_valid_o); end
      n_tests++; if (bus.theta_req_o !== 12'd0) begin n_fail++; $display("FAIL stall_theta[%0d]: got %0d expected 0", i, bus.theta_req_o); end
      if (i == 2) begin
        step();
        bus.enable_i = 1'b0;
      end
    end
    step();
    bus.theta_req_ready_i = 1'b1;
    repeat (25) @(negedge clk);
    n_tests++; if (req_log.size() != 1) begin n_fail++; $display("FAIL drain_reqs: got %0d expected 1", req_log.size()); end
    n_tests++; if (bus.theta_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", bus.theta_req_valid_o); end
    n_tests++; if (tick_log.size() != 1) begin n_fail++; $display("FAIL drain_ticks: got %0d expected 1", tick_log.size()); end
    if (tick_log.size() > 0) begin
      n_tests++; if (tick_log[0].tick !== 16'd100) begin n_fail++; $display("FAIL drain_tick: got %0d expected 100", tick_log[0].tick); end
    end
    step();
    bus.enable_i = 1'b1;
    k = 0;
    while (tick_log.size() < 2 && k < 40) begin @(negedge clk); k++; end
    n_tests++; if (tick_log.size() < 2) begin n_fail++; $display("FAIL restart_timeout: got %0d ticks expected 2", tick_log.size()); end
    if (req_log.size() > 1) begin
      n_tests++; if (req_log[1] !== 12'd0) begin n_fail++; $display("FAIL restart_theta: got %0d expected 0", req_log[1]); end
    end
    if (tick_log.size() > 1) begin
      n_tests++; if (tick_log[1].dir !== 1'b0) begin n_fail++; $display("FAIL restart_dir: got %b expected 0", tick_log[1].dir); end
      n_tests++; if (tick_log[1].tick !== 16'd100) begin n_fail++; $display("FAIL restart_tick: got %0d expected 100", tick_log[1].tick); end
    end
    quiesce();
  endtask

  task automatic test_err();
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b expected 0", bus.err_o); end
    @(negedge clk);
    n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", bus.err_o); end
    n_tests++; if (bus.fifo_level_o !== '0) begin n_fail++; $display("FAIL err_level: got %0d expected 0", bus.fifo_level_o); end
    repeat (5) @(negedge clk);
    n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_held: got %b expected 1", bus.err_o); end
    do_reset();
    @(negedge clk);
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", bus.err_o); end
  endtask

  task automatic test_reset_mid();
    int k;
    step();
    bus.bidir_i = 1'b1;
    bus.theta_req_ready_i = 1'b1;
    bus.tick_ready_i = 1'b0;
    bus.enable_i = 1'b1;
    k = 0;
    while (bus.fifo_level_o !== 4'd2 && k < 60) begin @(negedge clk); k++; end
    n_tests++; if (bus.fifo_level_o !== 4'd2) begin n_fail++; $display("FAIL midrst_setup: got level %0d expected 2", bus.fifo_level_o); end
    step();
    rst = 1'b1;
    bus.enable_i = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.theta_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", bus.theta_req_valid_o); end
    n_tests++; if (bus.theta_req_o !== '0) begin n_fail++; $display("FAIL midrst_theta: got %0d expected 0", bus.theta_req_o); end
    n_tests++; if (bus.tick_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_tick_valid: got %b expected 0", bus.tick_valid_o); end
    n_tests++; if (bus.tick_o !== '0) begin n_fail++; $display("FAIL midrst_tick: got %0d expected 0", bus.tick_o); end
    n_tests++; if (bus.line_end_o !== 1'b0 || bus.tick_dir_o !== 1'b0) begin n_fail++; $display("FAIL midrst_tags: got le %b dir %b expected 0 0", bus.line_end_o, bus.tick_dir_o); end
    n_tests++; if (bus.fifo_level_o !== '0) begin n_fail++; $display("FAIL midrst_level: got %0d expected 0", bus.fifo_level_o); end
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", bus.err_o); end
    k = 0;
    while (bus.err_o !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_tests++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL midrst_late_err: got %b expected 1", bus.err_o); end
    n_tests++; if (bus.fifo_level_o !== '0) begin n_fail++; $display("FAIL midrst_late_level: got %0d expected 0", bus.fifo_level_o); end
    quiesce();
  endtask

  initial begin
    bus.enable_i = 1'b0;
    bus.bidir_i = 1'b0;
    bus.theta_req_ready_i = 1'b1;
    bus.tick_ready_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_sweep(1'b1, 12);
    test_sweep(1'b0, 8);
    test_credit();
    test_stall_drain();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
